// File: rtl/ad9866_spi_arbiter.sv
// Two-requester round-robin SPI master for the AD9866 register port.
// It sequences the device hardware reset and then serializes 16-bit read/write frames.
module ad9866_spi_arbiter #(
  parameter int CLK_DIV     = 4,
  parameter int RST_CYCLES  = 64,
  parameter int WAIT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_rw,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rw,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       rd_src,
  output logic       init_done,
  output logic       busy,
  output logic       ad9866_rst_n,
  output logic       ad9866_sen_n,
  output logic       ad9866_sclk,
  output logic       ad9866_sdio,
  input  logic       ad9866_sdo
);

  typedef enum logic [2:0] {RST_HOLD, RST_WAIT, IDLE, SHIFT, GAP} state_t;

  localparam int CNT_MAX = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);
  localparam logic [7:0]    DIV_LAST  = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]  div_q, div_d;
  logic        phase_q, phase_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shift_q, shift_d;
  logic        rw_q, rw_d;
  logic        src_q, src_d;
  logic        last_q, last_d;
  logic [7:0]  rd_shift_q, rd_shift_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_src_q, rd_src_d;
  logic        gnt0, gnt1;
  logic        sel_rw;
  logic [6:0]  sel_addr;
  logic [7:0]  sel_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RST_HOLD;
      cnt_q      <= '0;
      div_q      <= '0;
      phase_q    <= 1'b0;
      bit_q      <= '0;
      shift_q    <= '0;
      rw_q       <= 1'b0;
      src_q      <= 1'b0;
      last_q     <= 1'b1;
      rd_shift_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_src_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      src_q      <= src_d;
      last_q     <= last_d;
      rd_shift_q <= rd_shift_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_src_q   <= rd_src_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    src_d      = src_q;
    last_d     = last_q;
    rd_shift_d = rd_shift_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_src_d   = rd_src_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    sel_rw     = 1'b0;
    sel_addr   = '0;
    sel_data   = '0;

    case (state_q)
      RST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = RST_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        // On a tie the requester that did not win last time gets the slot.
        gnt0     = req0_valid && (!req1_valid || last_q);
        gnt1     = req1_valid && !gnt0;
        sel_rw   = gnt1 ? req1_rw   : req0_rw;
        sel_addr = gnt1 ? req1_addr : req0_addr;
        sel_data = gnt1 ? req1_data : req0_data;
        if (gnt0 || gnt1) begin
          src_d   = gnt1;
          last_d  = gnt1;
          rw_d    = sel_rw;
          shift_d = {sel_rw, sel_addr, sel_rw ? 8'h00 : sel_data};
          div_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            // bit_q 8..15 carry the data byte, where the device answers reads.
            if (bit_q[3]) rd_shift_d = {rd_shift_q[6:0], ad9866_sdo};
          end else begin
            phase_d = 1'b0;
            if (bit_q == 4'd15) begin
              state_d = GAP;
              if (rw_q) begin
                rd_data_d  = rd_shift_q;
                rd_valid_d = 1'b1;
                rd_src_d   = src_q;
              end
            end else begin
              bit_d   = bit_q + 4'd1;
              shift_d = {shift_q[14:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      GAP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = RST_HOLD;
    endcase
  end

  assign req0_ready   = gnt0;
  assign req1_ready   = gnt1;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign rd_src       = rd_src_q;
  assign init_done    = (state_q == IDLE) || (state_q == SHIFT) || (state_q == GAP);
  assign busy         = (state_q == SHIFT) || (state_q == GAP);
  assign ad9866_rst_n = (state_q != RST_HOLD);
  assign ad9866_sen_n = (state_q != SHIFT);
  assign ad9866_sclk  = (state_q == SHIFT) && phase_q;
  assign ad9866_sdio  = (state_q == SHIFT) && shift_q[15];

endmodule

// File: doc/ad9866_spi_arbiter.md
AD9866_SPI_ARBITER -- requirements
Module: ad9866_spi_arbiter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles, legal range 2..255.
REQ-002 SHALL have parameter RST_CYCLES, default 64: clk cycles ad9866_rst_n is held low after reset.
REQ-003 SHALL have parameter WAIT_CYCLES, default 256: clk cycles from ad9866_rst_n high to first grant.
REQ-004 SHALL provide ports, one clock, synchronous active-high reset:
  clk          in   1  sole clock
  rst          in   1  synchronous active-high reset
  req0_valid   in   1  requester 0 (protocol/host) command valid
  req0_rw      in   1  1=read, 0=write
  req0_addr    in   7  AD9866 register address
  req0_data    in   8  write data (ignored on read)
  req0_ready   out  1  one-cycle grant/accept strobe
  req1_valid, req1_rw, req1_addr[6:0], req1_data[7:0], req1_ready  same as req0 (gain/PGA updater)
  rd_data      out  8  last read byte
  rd_valid     out  1  one-cycle strobe, rd_data valid
  rd_src       out  1  requester index of the read
  init_done    out  1  AD9866 out of reset, arbiter live
  busy         out  1  frame in progress (not IDLE)
  ad9866_rst_n out  1  AD9866 hardware reset, active low
  ad9866_sen_n out  1  SPI enable, active low
  ad9866_sclk  out  1  SPI clock
  ad9866_sdio  out  1  SPI data to device
  ad9866_sdo   in   1  SPI data from device

Function
REQ-005 SHALL implement states RST_HOLD, RST_WAIT, IDLE, SHIFT, GAP.
REQ-006 RST_HOLD: ad9866_rst_n=0 for RST_CYCLES cycles, then RST_WAIT.
REQ-007 RST_WAIT: ad9866_rst_n=1 for WAIT_CYCLES cycles, then IDLE; init_done=1 from first IDLE cycle until next rst.
REQ-008 No reqN_ready SHALL assert before init_done=1; valid requests in RST_* are held, not dropped.
REQ-009 In IDLE, a cycle with any reqN_valid=1 SHALL be the grant cycle: exactly one reqN_ready=1, rw/addr/data captured that cycle, next state SHIFT.
REQ-010 Arbitration: only one valid -> grant it; both valid -> grant the requester not granted last (round-robin); after reset last-granted = 1, so req0 wins first tie.
REQ-011 Requesters SHALL hold fields stable while valid and ready low; arbiter never asserts ready outside IDLE.
REQ-012 Frame SHALL be 16 bits MSB first: {rw, addr[6:0], data[7:0]}; for reads data field sent as 0x00.
REQ-013 SHIFT starts cycle after grant: sen_n=0; each bit occupies 2*CLK_DIV cycles, first CLK_DIV with sclk=0, next CLK_DIV with sclk=1; sdio updates only at bit start (sclk low).
REQ-014 For reads, ad9866_sdo SHALL be sampled on the clk edge where sclk goes 0->1 during bits 7..0, shifted in MSB first.
REQ-015 After bit 0 high phase, GAP: sen_n=1, sclk=0, sdio=0 for CLK_DIV cycles, then IDLE.
REQ-016 Read: rd_data updated and rd_valid=1 with rd_src for exactly the first GAP cycle; rd_data holds until next read; writes never pulse rd_valid.
REQ-017 Grant-to-grant minimum spacing SHALL be 1+33*CLK_DIV cycles; sen_n low exactly 32*CLK_DIV cycles per frame.
REQ-018 busy=1 in SHIFT and GAP, 0 otherwise.
REQ-019 Bit and divider counters SHALL be sized for CLK_DIV=255 without overflow.

Reset
REQ-020 rst=1 at any cycle (incl. mid-frame) SHALL, on the next edge: state RST_HOLD, ad9866_rst_n=0, sen_n=1, sclk=0, sdio=0, reqN_ready=0, rd_valid=0, rd_data=0x00, rd_src=0, init_done=0, busy=0, last-granted=1; in-flight frame abandoned, no rd_valid.
REQ-021 Reset SHALL remain effective for every cycle rst=1; counting resumes from zero after rst falls.

Verification
REQ-022 Power-up, defaults: rst released -> rst_n low 64 cycles, high 256 cycles, then init_done=1; no ready before.
REQ-023 Write req0 addr 0x05 data 0xA3 -> bitstream 0x05A3 on sdio over 128 cycles, sen_n low 128 cycles, no rd_valid.
REQ-024 Read req1 addr 0x1F, sdo model drives 0x5C -> sdio shows 0x9F00, rd_data=0x5C, rd_src=1, rd_valid single cycle in GAP.
REQ-025 req0 and req1 held valid continuously -> grants alternate 0,1,0,1, spacing exactly 133 cycles.
REQ-026 rst asserted at bit 6 of a read frame -> sen_n=1 next cycle, no rd_valid, full RST_HOLD/RST_WAIT rerun, pending requests later served.
REQ-027 CLK_DIV=2, RST_CYCLES=4, WAIT_CYCLES=4 -> frame 64 cycles, first grant 8 cycles after rst falls.
